dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter
// ----------------------------------------------------------------------------
// Arbitrates two masters (m0 = CPU, m1 = debug loader) onto one shared data
// memory port. One access is in flight at a time:
//   IDLE  -> a request is sampled, the winner's command is registered
//   ISSUE -> the registered command is driven with a one-cycle read or write
//            enable, and the winner's gnt pulses
//   WAIT  -> reads only: MEM_LAT cycles; rvalid pulses in the last one
// Requests are ignored outside IDLE.
//
// Parameters
//   MEM_LAT          memory read latency in cycles, strobe to data (1..4)
//
// Build option
//   DMEM_ARB_RR_EN   when defined, simultaneous requests are arbitrated
//                    round-robin (the master not granted last wins).
//                    Otherwise m0 always wins and there is no pointer register.
//
// Ports
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   m<k>_req_i/we_i                request, 1 = write / 0 = read
//   m<k>_addr_i/wdata_i            address, write data
//   m<k>_sign_mask_i               size/sign code, forwarded unmodified
//   m<k>_gnt_o                     one-cycle pulse: access issued to memory
//   m<k>_rvalid_o                  one-cycle pulse: m<k>_rdata_o is valid
//   m<k>_rdata_o                   combinational copy of mem_rdata_i
//   mem_addr_o/wdata_o/sign_mask_o registered command to memory
//   mem_w_ena_o/mem_r_ena_o        one-cycle strobes, high only in ISSUE
//   mem_rdata_i                    read data from memory
// ============================================================================
module dmem_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [2:0]  m0_sign_mask_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [2:0]  m1_sign_mask_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_w_ena_o,
    output logic        mem_r_ena_o,
    output logic [2:0]  mem_sign_mask_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // WAIT counter start value: counts MEM_LAT-1 down to 0.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        owner_q;     // 0 = m0, 1 = m1 owns the current access
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  mask_q;
    logic        gnt_q;
    logic        w_ena_q;
    logic        r_ena_q;
    logic        rvalid_q;

    logic        any_req;
    logic        win_d;       // next owner if a request is accepted this edge
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_mask;

    assign any_req = m0_req_i | m1_req_i;

`ifdef DMEM_ARB_RR_EN
    logic last_q;             // 1 = m1 was granted last

    // On a tie the master not granted last wins; a lone requester always wins.
    assign win_d = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;
`else
    assign win_d = ~m0_req_i;
`endif

    // NOTE: every output of a combinational block is given a value on every
    // path (here by the ternaries), so no latch can be inferred.
    always_comb begin
        sel_we    = win_d ? m1_we_i        : m0_we_i;
        sel_addr  = win_d ? m1_addr_i      : m0_addr_i;
        sel_wdata = win_d ? m1_wdata_i     : m0_wdata_i;
        sel_mask  = win_d ? m1_sign_mask_i : m0_sign_mask_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and the defaults at the top of the
    // block can be overridden later in the same block without ordering races.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            mask_q   <= 3'd0;
            gnt_q    <= 1'b0;
            w_ena_q  <= 1'b0;
            r_ena_q  <= 1'b0;
            rvalid_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            // Pulses default low; each is raised for exactly one cycle below.
            gnt_q    <= 1'b0;
            w_ena_q  <= 1'b0;
            r_ena_q  <= 1'b0;
            rvalid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= win_d;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        mask_q  <= sel_mask;
                        gnt_q   <= 1'b1;
                        w_ena_q <= sel_we;
                        r_ena_q <= ~sel_we;
                        state_q <= ISSUE;
`ifdef DMEM_ARB_RR_EN
                        last_q  <= win_d;
`endif
                    end
                end

                ISSUE: begin
                    if (we_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= WAIT;
                        cnt_q    <= LAT_M1;
                        // Single-cycle WAIT: its only cycle is also the last.
                        rvalid_q <= (LAT_M1 == 2'd0);
                    end
                end

                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q    <= cnt_q - 2'd1;
                        // Entering the final WAIT cycle.
                        rvalid_q <= (cnt_q == 2'd1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Pulses are registered; routing by owner_q keeps them mutually exclusive.
    assign m0_gnt_o    = gnt_q & ~owner_q;
    assign m1_gnt_o    = gnt_q &  owner_q;
    assign m0_rvalid_o = rvalid_q & ~owner_q;
    assign m1_rvalid_o = rvalid_q &  owner_q;
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    assign mem_addr_o      = addr_q;
    assign mem_wdata_o     = wdata_q;
    assign mem_sign_mask_o = mask_q;
    assign mem_w_ena_o     = w_ena_q;
    assign mem_r_ena_o     = r_ena_q;

endmodule
